// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: clocked hazard, forwarding and redirect controller for
// the 5-stage pipeline. It sits beside the ID/EX registers and drives the PC,
// IF/ID and ID/EX control inputs and the EX operand muxes.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> 16-bit saturating stall/flush statistics counters
//   undefined -> stall_count/flush_count tied to 0, no counter flops
//
// FSM states
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_RUN   | normal issue; load-use and taken redirects evaluated here
//   S_STALL | extra load-use stall cycles; cnt counts the remaining ones
//   S_FLUSH | extra IF/ID flush cycles after a redirect; cnt as above
//
// While rst is low every control output is forced to its safe value
// combinationally, so a reset in mid-sequence takes effect at once.

module pipe_hazard_ctrl #(
    parameter int AW          = 5,
    parameter int FWD_STAGES  = 2,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1,
    localparam int SW         = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [AW-1:0]              id_rs,
    input  logic [AW-1:0]              id_rt,
    input  logic                       id_uses_rs,
    input  logic                       id_uses_rt,
    input  logic [1:0]                 id_branch,
    input  logic                       regs_equal,
    input  logic                       ex_valid,
    input  logic                       ex_mem_read,
    input  logic [AW-1:0]              ex_rs,
    input  logic [AW-1:0]              ex_rt,
    input  logic [AW-1:0]              ex_wreg,
    input  logic [FWD_STAGES*AW-1:0]   fwd_wreg,
    input  logic [FWD_STAGES-1:0]      fwd_wen,
    output logic [SW-1:0]              fwd_sel_a,
    output logic [SW-1:0]              fwd_sel_b,
    output logic                       pc_write,
    output logic                       ifid_write,
    output logic                       idex_bubble,
    output logic                       ifid_flush,
    output logic                       pc_src,
    output logic                       busy,
    output logic [15:0]                stall_count,
    output logic [15:0]                flush_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JUMP = 2'b11;

    // cnt holds the cycles still to go after the current one, so the
    // entry value is the total length minus the RUN cycle that started it.
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_LAT - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_SLOTS - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [SW-1:0] sel_a, sel_b;
    logic          found_a, found_b;

    logic lu, tk;
    logic ctl_pc_write, ctl_ifid_write, ctl_idex_bubble;
    logic ctl_ifid_flush, ctl_pc_src;
    logic stall_cycle;

    // Forward select: the youngest (lowest-index) writing stage wins.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            if (!found_a && fwd_wen[k] && (ex_rs != '0) &&
                (fwd_wreg[k*AW +: AW] == ex_rs)) begin
                sel_a   = SW'(k + 1);
                found_a = 1'b1;
            end
            if (!found_b && fwd_wen[k] && (ex_rt != '0) &&
                (fwd_wreg[k*AW +: AW] == ex_rt)) begin
                sel_b   = SW'(k + 1);
                found_b = 1'b1;
            end
        end
    end

    assign fwd_sel_a = (rst && ex_valid) ? sel_a : '0;
    assign fwd_sel_b = (rst && ex_valid) ? sel_b : '0;

    // Hazard detection; both act in the same cycle they are seen.
    assign lu = ex_valid && ex_mem_read && (ex_wreg != '0) && id_valid &&
                ((id_uses_rs && (id_rs == ex_wreg)) ||
                 (id_uses_rt && (id_rt == ex_wreg)));

    assign tk = id_valid && ((id_branch == BR_JUMP) ||
                             ((id_branch == BR_BEQ) &&  regs_equal) ||
                             ((id_branch == BR_BNE) && !regs_equal));

    // State and countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and pipeline controls; load-use beats a redirect because
    // the branch operands are not ready yet, and the branch re-evaluates
    // once the stall is over.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ctl_pc_write    = 1'b1;
        ctl_ifid_write  = 1'b1;
        ctl_idex_bubble = 1'b0;
        ctl_ifid_flush  = 1'b0;
        ctl_pc_src      = 1'b0;
        stall_cycle     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (lu) begin
                    ctl_pc_write    = 1'b0;
                    ctl_ifid_write  = 1'b0;
                    ctl_idex_bubble = 1'b1;
                    stall_cycle     = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = S_STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end else if (tk) begin
                    ctl_pc_src     = 1'b1;
                    ctl_ifid_flush = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end
                end
            end
            S_STALL: begin
                ctl_pc_write    = 1'b0;
                ctl_ifid_write  = 1'b0;
                ctl_idex_bubble = 1'b1;
                stall_cycle     = 1'b1;
                cnt_d           = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                ctl_ifid_flush = 1'b1;
                cnt_d          = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    assign pc_write    = rst ? ctl_pc_write    : 1'b0;
    assign ifid_write  = rst ? ctl_ifid_write  : 1'b0;
    assign idex_bubble = rst ? ctl_idex_bubble : 1'b1;
    assign ifid_flush  = rst ? ctl_ifid_flush  : 1'b0;
    assign pc_src      = rst ? ctl_pc_src      : 1'b0;
    assign busy        = rst && (state_q != S_RUN);

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating increments for the statistics counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (ctl_ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Statistics registers, cleared with the rest of the unit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (AW=5, FWD_STAGES=2, LOAD_LAT=3,
// FLUSH_SLOTS=2). A reference model tracks remaining stall/flush cycles as
// plain integers and derives every expected output each cycle.

module tb_pipe_hazard_ctrl;

    localparam int AW          = 5;
    localparam int FWD_STAGES  = 2;
    localparam int LOAD_LAT    = 3;
    localparam int FLUSH_SLOTS = 2;
    localparam int SW          = $clog2(FWD_STAGES + 1);

    logic                     clk;
    logic                     rst;
    logic                     id_valid;
    logic [AW-1:0]            id_rs, id_rt;
    logic                     id_uses_rs, id_uses_rt;
    logic [1:0]               id_branch;
    logic                     regs_equal;
    logic                     ex_valid, ex_mem_read;
    logic [AW-1:0]            ex_rs, ex_rt, ex_wreg;
    logic [FWD_STAGES*AW-1:0] fwd_wreg;
    logic [FWD_STAGES-1:0]    fwd_wen;
    logic [SW-1:0]            fwd_sel_a, fwd_sel_b;
    logic                     pc_write, ifid_write, idex_bubble;
    logic                     ifid_flush, pc_src, busy;
    logic [15:0]              stall_count, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_stall_left = 0;
    int m_flush_left = 0;
    int m_stall_cnt  = 0;
    int m_flush_cnt  = 0;

    logic obs_pcw, obs_busy, obs_src, obs_flush;

    pipe_hazard_ctrl #(
        .AW(AW), .FWD_STAGES(FWD_STAGES),
        .LOAD_LAT(LOAD_LAT), .FLUSH_SLOTS(FLUSH_SLOTS)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .regs_equal(regs_equal),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .fwd_wreg(fwd_wreg), .fwd_wen(fwd_wen),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .pc_src(pc_src), .busy(busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fwd_ref(input logic [AW-1:0] r);
        if (!ex_valid || r == 0) return 0;
        for (int k = 0; k < FWD_STAGES; k++)
            if (fwd_wen[k] && fwd_wreg[k*AW +: AW] == r) return k + 1;
        return 0;
    endfunction

    // Called at a falling edge with inputs already driven: checks this
    // cycle's outputs, then advances the model across the rising edge.
    task automatic tick();
        int  ea, eb, ns, nf;
        bit  lu, tk, e_pcw, e_ifw, e_bub, e_fl, e_src, e_busy, st;
        #1;
        ea = fwd_ref(ex_rs);
        eb = fwd_ref(ex_rt);
        lu = ex_valid && ex_mem_read && ex_wreg != 0 && id_valid &&
             ((id_uses_rs && id_rs == ex_wreg) || (id_uses_rt && id_rt == ex_wreg));
        tk = id_valid && (id_branch == 2'b11 || (id_branch == 2'b01 && regs_equal) ||
                          (id_branch == 2'b10 && !regs_equal));
        ns = m_stall_left; nf = m_flush_left;
        e_busy = (m_stall_left > 0) || (m_flush_left > 0);
        e_pcw = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_src = 0; st = 0;
        if (m_stall_left > 0) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1; st = 1; ns = m_stall_left - 1;
        end else if (m_flush_left > 0) begin
            e_fl = 1; nf = m_flush_left - 1;
        end else if (lu) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1; st = 1; ns = LOAD_LAT - 1;
        end else if (tk) begin
            e_src = 1; e_fl = 1; nf = FLUSH_SLOTS - 1;
        end
        if (!rst) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_src = 0;
            e_busy = 0; ea = 0; eb = 0; st = 0;
        end
        check_val("fwd_sel_a",   32'(fwd_sel_a),   32'(ea));
        check_val("fwd_sel_b",   32'(fwd_sel_b),   32'(eb));
        check_val("pc_write",    32'(pc_write),    32'(e_pcw));
        check_val("ifid_write",  32'(ifid_write),  32'(e_ifw));
        check_val("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check_val("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        check_val("pc_src",      32'(pc_src),      32'(e_src));
        check_val("busy",        32'(busy),        32'(e_busy));
        obs_pcw = pc_write; obs_busy = busy; obs_src = pc_src; obs_flush = ifid_flush;
        @(posedge clk);
        if (rst) begin
            m_stall_left = ns;
            m_flush_left = nf;
            if (st && m_stall_cnt < 65535) m_stall_cnt++;
            if (e_fl && m_flush_cnt < 65535) m_flush_cnt++;
        end else begin
            m_stall_left = 0; m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_branch = 2'b00; regs_equal = 0;
        ex_valid = 0; ex_mem_read = 0; ex_rs = 0; ex_rt = 0; ex_wreg = 0;
        fwd_wreg = '0; fwd_wen = '0;
    endtask

    task automatic set_load_use();
        ex_valid = 1; ex_mem_read = 1; ex_wreg = 5'd5;
        id_valid = 1; id_uses_rs = 1; id_rs = 5'd5;
    endtask

    task automatic check_stats();
`ifdef HAZARD_STATS_EN
        check_val("stall_count", 32'(stall_count), 32'(m_stall_cnt));
        check_val("flush_count", 32'(flush_count), 32'(m_flush_cnt));
`else
        check_val("stall_count", 32'(stall_count), 32'd0);
        check_val("flush_count", 32'(flush_count), 32'd0);
`endif
    endtask

    initial begin
        int n_stall, n_busy, n_src;
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        tick();
        check_val("rst_bubble", 32'(idex_bubble), 32'd1);
        check_val("rst_pcw",    32'(pc_write),    32'd0);
        check_stats();
        rst = 1'b1;
        tick();

        // Forwarding priority and the r0 exclusion.
        ex_valid = 1; ex_rs = 5'd3; fwd_wreg = {5'd3, 5'd3}; fwd_wen = 2'b11;
        tick();
        check_val("fwd_mem", 32'(obs_pcw ? fwd_sel_a : 2'd3), 32'd1);
        fwd_wen = 2'b10;
        tick();
        check_val("fwd_wb", 32'(fwd_sel_a), 32'd2);
        ex_rs = 5'd0;
        tick();
        check_val("fwd_r0", 32'(fwd_sel_a), 32'd0);
        idle_inputs();

        // Load-use held for the full stall.
        set_load_use();
        n_stall = 0; n_busy = 0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            tick();
            if (!obs_pcw) n_stall++;
            if (obs_busy) n_busy++;
        end
        idle_inputs();
        tick();
        if (!obs_pcw) n_stall++;
        check_val("lu_stall_len", 32'(n_stall), 32'(LOAD_LAT));
        check_val("lu_busy_len",  32'(n_busy),  32'(LOAD_LAT - 1));

        // Taken beq, then a not-taken bne.
        id_valid = 1; id_branch = 2'b01; regs_equal = 1;
        tick();
        check_val("beq_src", 32'(obs_src), 32'd1);
        id_branch = 2'b00;
        tick();
        check_val("beq_flush2", 32'(obs_flush), 32'd1);
        id_branch = 2'b10;
        tick();
        check_val("bne_noflush", 32'(obs_flush), 32'd0);
        idle_inputs();

        // Load-use and jump together: stall wins, jump follows.
        set_load_use(); id_branch = 2'b11;
        n_src = 0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            tick();
            if (obs_src) n_src++;
        end
        check_val("lu_jump_nosrc", 32'(n_src), 32'd0);
        ex_valid = 0;
        tick();
        check_val("jump_after", 32'(obs_src), 32'd1);
        idle_inputs();
        tick();

        // Reset during the second stall cycle aborts the stall.
        set_load_use();
        tick();
        rst = 1'b0;
        tick();
        check_val("mid_rst_pcw",  32'(obs_pcw),  32'd0);
        check_val("mid_rst_busy", 32'(obs_busy), 32'd0);
        idle_inputs();
        rst = 1'b1;
        tick();
        check_val("post_rst_pcw", 32'(obs_pcw), 32'd1);

        // Randomized traffic with a small register space to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) != 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs       = AW'($urandom_range(0, 3));
            id_rt       = AW'($urandom_range(0, 3));
            id_uses_rs  = 1'($urandom);
            id_uses_rt  = 1'($urandom);
            id_branch   = 2'($urandom);
            regs_equal  = 1'($urandom);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rs       = AW'($urandom_range(0, 3));
            ex_rt       = AW'($urandom_range(0, 3));
            ex_wreg     = AW'($urandom_range(0, 3));
            fwd_wreg    = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
            fwd_wen     = 2'($urandom);
            tick();
            if (i % 100 == 99) check_stats();
        end
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_stats();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and redirect controller for the 5-stage pipeline. It replaces the purely combinational forwarding and stall logic with a clocked unit. The unit supports a configurable number of forwarding stages, multi-cycle load-use stalls for slower data memories, and multi-slot fetch flushes after taken branches and jumps. It sits beside the ID/EX pipeline registers and drives the PC, IF/ID and ID/EX control inputs and the EX operand muxes.

## Interface
- AW, 5, register address width
- FWD_STAGES, 2, later stages offering forwarding (1..4); stage 0 = MEM, 1 = WB, ...
- LOAD_LAT, 1, load-use stall length in cycles (1..4)
- FLUSH_SLOTS, 1, IF/ID flush cycles per taken redirect (1..3)
- SW, $clog2(FWD_STAGES+1), forward select width (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID actually reads rs / rt
- id_branch  in  2  00 none, 01 beq, 10 bne, 11 jump
- regs_equal  in  1  ID register comparator result
- ex_valid, ex_mem_read  in  1  EX instruction valid / is a load
- ex_rs, ex_rt, ex_wreg  in  AW  EX sources and destination
- fwd_wreg  in  FWD_STAGES*AW  destination per stage, stage k at [k*AW +: AW]
- fwd_wen  in  FWD_STAGES  register-write enable per stage
- fwd_sel_a, fwd_sel_b  out  SW  0 = register file, k = stage k-1
- pc_write, ifid_write  out  1  PC / IF/ID load enables
- idex_bubble  out  1  zero ID/EX control fields
- ifid_flush  out  1  clear IF/ID
- pc_src  out  1  select branch/jump target
- busy  out  1  FSM not in RUN
- stall_count, flush_count  out  16  statistics (see Configuration)

## Operation
- Forwarding (combinational):
  - fwd_sel_a is the lowest k with fwd_wen[k], fwd_wreg[k]==ex_rs and ex_rs!=0; the output is k+1, else 0.
  - fwd_sel_b is derived the same way from ex_rt.
  - When ex_valid=0, both selects are 0.
- Load-use hazard (lu): ex_valid & ex_mem_read & ex_wreg!=0 & id_valid & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
- Taken (tk): id_valid & (id_branch==11 | (id_branch==01 & regs_equal) | (id_branch==10 & ~regs_equal)).
- FSM states RUN, STALL, FLUSH; 2-bit down-counter cnt.
- RUN:
  - If lu: stall this cycle (pc_write=0, ifid_write=0, idex_bubble=1). If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - Else if tk: pc_src=1 and ifid_flush=1. If FLUSH_SLOTS>1, go to FLUSH with cnt=FLUSH_SLOTS-1.
  - Else: pc_write=1, ifid_write=1, all other controls 0.
- STALL:
  - Same stall outputs as the first stall cycle.
  - cnt decrements; return to RUN when cnt==1 at the clock edge.
  - lu and tk are ignored.
- FLUSH:
  - pc_write=1, ifid_write=1, ifid_flush=1, pc_src=0.
  - cnt decrements; return to RUN when cnt==1.
  - lu and tk are ignored.
- Priority: lu over tk, because the branch operand is not ready. The branch re-evaluates after the stall.
- busy = (state != RUN).

## Timing
- Forward selects, lu and tk all act in the same cycle (zero latency). The FSM updates on the rising clk edge.
- Total stall per load-use = LOAD_LAT cycles. Total flush per redirect = FLUSH_SLOTS cycles.
- While rst is low:
  - state=RUN, cnt=0, counters 0.
  - Outputs forced: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pc_src=0, fwd_sel_a/b=0, busy=0.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence immediately. The first cycle after release is RUN.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments once per stall cycle; flush_count increments once per ifid_flush cycle.
  - Both counters are 16-bit and saturate at 16'hFFFF.
  - Both are cleared by rst.
- HAZARD_STATS_EN undefined: the ports remain and are driven constant 0. No counter flops are synthesised.

## Test plan
- Forwarding, FWD_STAGES=2: ex_rs=3, fwd_wreg={3,3}, fwd_wen=2'b11 -> fwd_sel_a=1. Then fwd_wen=2'b10 -> fwd_sel_a=2. Then ex_rs=0 -> fwd_sel_a=0.
- Load-use, LOAD_LAT=3: ex load to r5, ID uses rs=5 -> exactly 3 cycles of pc_write=0, idex_bubble=1; busy=1 for the last 2; then RUN.
- Branch, FLUSH_SLOTS=2: beq with regs_equal=1 -> pc_src=1 for 1 cycle, ifid_flush=1 for 2 cycles. bne with regs_equal=1 -> no flush.
- Simultaneous lu and jump in RUN -> stall only, no pc_src. After the stall ends the jump is taken.
- rst pulsed low in the 2nd cycle of a 4-cycle stall -> outputs take their reset values asynchronously; the first cycle after release shows pc_write=1.
- With HAZARD_STATS_EN: 2 load-use stalls at LOAD_LAT=2 plus 1 jump at FLUSH_SLOTS=3 -> stall_count=4, flush_count=3. Without the macro -> both 0.
